// File: rtl/cluster_map_decoder_if.sv
// Cluster word stream in, rebuilt pad map out, for cluster_map_decoder.
// Signal names follow the decoder's pin list; master drives words, slave rebuilds maps.
interface cluster_map_decoder_if #(
    parameter int MXKEYS    = 192,
    parameter int MXKEYBITS = 8,
    parameter int MXCNTB    = 3
);
    logic                       valid_i;
    logic                       last_i;
    logic [2:0]                 pass_i;
    logic [MXKEYBITS-1:0]       adr_i;
    logic                       vpf_i;
    logic [MXCNTB-1:0]          cnt_i;

    logic [MXKEYS-1:0]          vpfs_o;
    logic [MXKEYS*MXCNTB-1:0]   cnts_o;
    logic [MXKEYS-1:0]          hits_o;
    logic [2:0]                 pass_o;
    logic                       frame_valid_o;
    logic [3:0]                 nclusters_o;
    logic                       err_range_o;
    logic                       err_dup_o;
    logic                       err_ovf_o;

    modport master (
        output valid_i, last_i, pass_i, adr_i, vpf_i, cnt_i,
        input  vpfs_o, cnts_o, hits_o, pass_o, frame_valid_o, nclusters_o,
               err_range_o, err_dup_o, err_ovf_o
    );

    modport slave (
        input  valid_i, last_i, pass_i, adr_i, vpf_i, cnt_i,
        output vpfs_o, cnts_o, hits_o, pass_o, frame_valid_o, nclusters_o,
               err_range_o, err_dup_o, err_ovf_o
    );
endinterface

// File: rtl/cluster_map_decoder.sv
// Rebuilds the pad valid/count map from a serial cluster word stream, double-buffered per frame.
// Optional CLUSTER_EXPAND_EN: also builds a strip-occupancy map (pads adr..adr+cnt) on hits_o.
module cluster_map_decoder #(
    parameter int MXKEYS     = 192,
    parameter int MXKEYBITS  = 8,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    cluster_map_decoder_if.slave bus
);
    localparam int                   CNTW    = MXKEYS * MXCNTB;
    localparam int                   CBW     = $clog2(CNTW);
    localparam logic [MXKEYBITS:0]   KEY_LIM = (MXKEYBITS+1)'(MXKEYS);
    localparam logic [3:0]           CL_MAX  = 4'(MXCLUSTERS);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_first;

    // Working (accumulating) frame
    logic [MXKEYS-1:0]      r_wvpf;
    logic [CNTW-1:0]        r_wcnt;
    logic [3:0]             r_wcount;
    logic [2:0]             r_wpass;

    // Presented frame
    logic [MXKEYS-1:0]      r_vpfs;
    logic [CNTW-1:0]        r_cnts;
    logic [3:0]             r_ncl;
    logic [2:0]             r_pass;
    logic                   r_frame_valid;
    logic                   r_err_range;
    logic                   r_err_dup;
    logic                   r_err_ovf;

    logic [MXKEYS-1:0]      w_vpf_nxt;
    logic [CNTW-1:0]        w_cnt_nxt;
    logic [3:0]             w_count_nxt;
    logic [2:0]             w_pass_eff;
    logic                   w_set_range;
    logic                   w_set_dup;
    logic                   w_set_ovf;
    logic                   w_out_range;
    logic                   w_full;
    logic                   w_accept;
    logic [CBW-1:0]         w_cbase;

    assign w_out_range = ({1'b0, bus.adr_i} >= KEY_LIM);
    assign w_full      = (r_wcount == CL_MAX);
    assign w_accept    = bus.valid_i && bus.vpf_i && !w_out_range && !w_full;
    assign w_cbase     = CBW'(bus.adr_i) * CBW'(MXCNTB);
    assign w_pass_eff  = w_first ? bus.pass_i : r_wpass;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.valid_i && !bus.last_i) w_state_nxt = ACCUM;
            ACCUM:   if (bus.valid_i &&  bus.last_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_first = 1'b0;
        case (r_state)
            IDLE:    w_first = 1'b1;
            default: w_first = 1'b0;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_vpf_nxt   = r_wvpf;
        w_cnt_nxt   = r_wcnt;
        w_count_nxt = r_wcount;
        w_set_range = 1'b0;
        w_set_dup   = 1'b0;
        w_set_ovf   = 1'b0;
        if (bus.valid_i && bus.vpf_i) begin
            w_set_range = w_out_range;
            w_set_ovf   = w_full;
        end
        if (w_accept) begin
            w_set_dup                   = r_wvpf[bus.adr_i];
            w_vpf_nxt[bus.adr_i]        = 1'b1;
            w_cnt_nxt[w_cbase +: MXCNTB] = bus.cnt_i;
            w_count_nxt                 = r_wcount + 4'd1;
        end
    end

    // NOTE: the working and presented maps are flop arrays that must read as empty after reset, so they are reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wvpf        <= '0;
            r_wcnt        <= '0;
            r_wcount      <= '0;
            r_wpass       <= '0;
            r_vpfs        <= '0;
            r_cnts        <= '0;
            r_ncl         <= '0;
            r_pass        <= '0;
            r_frame_valid <= 1'b0;
            r_err_range   <= 1'b0;
            r_err_dup     <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_err_range   <= r_err_range | w_set_range;
            r_err_dup     <= r_err_dup   | w_set_dup;
            r_err_ovf     <= r_err_ovf   | w_set_ovf;
            if (bus.valid_i) begin
                if (w_first) r_wpass <= bus.pass_i;
                if (bus.last_i) begin
                    // Final word folded in, then presented; working side restarts empty.
                    r_vpfs        <= w_vpf_nxt;
                    r_cnts        <= w_cnt_nxt;
                    r_ncl         <= w_count_nxt;
                    r_pass        <= w_pass_eff;
                    r_frame_valid <= 1'b1;
                    r_wvpf        <= '0;
                    r_wcnt        <= '0;
                    r_wcount      <= '0;
                end else begin
                    r_wvpf   <= w_vpf_nxt;
                    r_wcnt   <= w_cnt_nxt;
                    r_wcount <= w_count_nxt;
                end
            end
        end
    end

`ifdef CLUSTER_EXPAND_EN
    logic [MXKEYS-1:0] r_whits;
    logic [MXKEYS-1:0] r_hits;
    logic [MXKEYS-1:0] w_span;
    logic [MXKEYS-1:0] w_hits_nxt;

    // Span adr..adr+cnt; indices past the top pad simply do not exist, giving the clip.
    always_comb begin
        w_span = '0;
        for (int k = 0; k < MXKEYS; k++) begin
            w_span[k] = (k >= int'(bus.adr_i)) && (k <= int'(bus.adr_i) + int'(bus.cnt_i));
        end
    end

    assign w_hits_nxt = w_accept ? (r_whits | w_span) : r_whits;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_whits <= '0;
            r_hits  <= '0;
        end else if (bus.valid_i) begin
            if (bus.last_i) begin
                r_hits  <= w_hits_nxt;
                r_whits <= '0;
            end else begin
                r_whits <= w_hits_nxt;
            end
        end
    end

    assign bus.hits_o = r_hits;
`else
    assign bus.hits_o = '0;
`endif

    assign bus.vpfs_o        = r_vpfs;
    assign bus.cnts_o        = r_cnts;
    assign bus.pass_o        = r_pass;
    assign bus.frame_valid_o = r_frame_valid;
    assign bus.nclusters_o   = r_ncl;
    assign bus.err_range_o   = r_err_range;
    assign bus.err_dup_o     = r_err_dup;
    assign bus.err_ovf_o     = r_err_ovf;
endmodule

// File: tb/tb_cluster_map_decoder.sv
// Randomized + directed bench for cluster_map_decoder against a per-pad array model.
module tb_cluster_map_decoder;
    localparam int NK = 192;
    localparam int NB = 3;
    localparam int NC = 8;
    localparam int W  = NK * NB;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cluster_map_decoder_if #(.MXKEYS(NK), .MXKEYBITS(8), .MXCNTB(NB)) bus ();

    cluster_map_decoder #(.MXKEYS(NK), .MXKEYBITS(8), .MXCNTB(NB), .MXCLUSTERS(NC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int fv_seen = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: per-pad arrays for the working frame, vectors for what should be presented
    bit             mw_vpf[NK];
    int             mw_cnt[NK];
    bit             mw_hit[NK];
    int             m_n;
    bit             m_in;
    logic [2:0]     m_pass;
    logic [NK-1:0]  o_vpf, o_hit;
    logic [W-1:0]   o_cnt;
    logic [2:0]     o_pass;
    logic [3:0]     o_n;
    bit             e_range, e_dup, e_ovf, exp_fv;

    function automatic void model_clear_work();
        for (int k = 0; k < NK; k++) begin
            mw_vpf[k] = 0; mw_cnt[k] = 0; mw_hit[k] = 0;
        end
        m_n = 0;
        m_in = 0;
    endfunction

    function automatic void model_reset();
        model_clear_work();
        o_vpf = '0; o_hit = '0; o_cnt = '0; o_pass = '0; o_n = '0;
        e_range = 0; e_dup = 0; e_ovf = 0; exp_fv = 0;
    endfunction

    function automatic void model_word(bit l, logic [2:0] p, int a, bit f, int c);
        if (!m_in) begin m_pass = p; m_in = 1; end
        if (f) begin
            if (a >= NK) e_range = 1;
            if (m_n == NC) e_ovf = 1;
            if (a < NK && m_n < NC) begin
                if (mw_vpf[a]) e_dup = 1;
                mw_vpf[a] = 1;
                mw_cnt[a] = c;
                m_n++;
                for (int k = a; k <= a + c && k < NK; k++) mw_hit[k] = 1;
            end
        end
        if (l) begin
            for (int k = 0; k < NK; k++) begin
                o_vpf[k] = mw_vpf[k];
                o_hit[k] = mw_hit[k];
                o_cnt[k*NB +: NB] = 3'(mw_cnt[k]);
            end
            o_pass = m_pass;
            o_n    = 4'(m_n);
            exp_fv = 1;
            model_clear_work();
        end
    endfunction

    task automatic check_outputs();
        if (bus.frame_valid_o === 1'b1) fv_seen++;
        check("frame_valid", W'(bus.frame_valid_o), W'(exp_fv));
        check("vpfs", W'(bus.vpfs_o), W'(o_vpf));
        check("cnts", bus.cnts_o, o_cnt);
        check("pass", W'(bus.pass_o), W'(o_pass));
        check("nclusters", W'(bus.nclusters_o), W'(o_n));
`ifdef CLUSTER_EXPAND_EN
        check("hits", W'(bus.hits_o), W'(o_hit));
`else
        check("hits_off", W'(bus.hits_o), '0);
`endif
        check("err_range", W'(bus.err_range_o), W'(e_range));
        check("err_dup", W'(bus.err_dup_o), W'(e_dup));
        check("err_ovf", W'(bus.err_ovf_o), W'(e_ovf));
    endtask

    // One cycle: check what the previous edge produced, then drive this cycle's word
    task automatic step(input bit v, input bit l, input logic [2:0] p, input logic [7:0] a,
                        input bit f, input logic [2:0] c);
        @(negedge clock);
        check_outputs();
        bus.valid_i = v; bus.last_i = l; bus.pass_i = p;
        bus.adr_i = a; bus.vpf_i = f; bus.cnt_i = c;
        exp_fv = 0;
        if (v) model_word(l, p, int'(a), f, int'(c));
    endtask

    task automatic send(input bit l, input logic [2:0] p, input logic [7:0] a, input logic [2:0] c);
        step(1'b1, l, p, a, 1'b1, c);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
    endtask

    logic [NK-1:0] a_mask;
    logic [NK-1:0] orig_vpf;
    logic [W-1:0]  orig_cnt;
    logic [NK-1:0] work;

    initial begin
        bus.valid_i = 0; bus.last_i = 0; bus.pass_i = 0;
        bus.adr_i = 0; bus.vpf_i = 0; bus.cnt_i = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Reset state, then single cluster
        idle();
        send(1'b1, 3'd3, 8'd5, 3'd2);
        idle();
        check("single_vpf", W'(bus.vpfs_o), W'(192'd1 << 5));
        check("single_cnt", W'(bus.cnts_o[17:15]), W'(3'd2));
        check("single_pass", W'(bus.pass_o), W'(3'd3));

        // Address range: 191 accepted, 200 dropped
        send(1'b0, 3'd1, 8'd191, 3'd7);
        send(1'b1, 3'd0, 8'd200, 3'd1);
        idle();
        check("range_n", W'(bus.nclusters_o), W'(4'd1));
        check("range_err", W'(bus.err_range_o), W'(1'b1));
`ifdef CLUSTER_EXPAND_EN
        check("range_hits", W'(bus.hits_o), W'(192'd1 << 191));
`endif

        // Overflow: 10 distinct pads, only the first 8 land
        for (int i = 0; i < 10; i++) send(i == 9, 3'd2, 8'(20 + i), 3'(i));
        idle();
        check("ovf_n", W'(bus.nclusters_o), W'(4'd8));
        check("ovf_vpf", W'(bus.vpfs_o), W'(192'hFF << 20));
        check("ovf_err", W'(bus.err_ovf_o), W'(1'b1));

        // Duplicate address overwrites the count
        send(1'b0, 3'd4, 8'd12, 3'd1);
        send(1'b1, 3'd4, 8'd12, 3'd4);
        idle();
        check("dup_cnt", W'(bus.cnts_o[38:36]), W'(3'd4));
        check("dup_err", W'(bus.err_dup_o), W'(1'b1));
        check("dup_n", W'(bus.nclusters_o), W'(4'd2));

        // Back-to-back frames, zero dead cycles
        fv_seen = 0;
        a_mask = (192'd1 << 40) | (192'd1 << 41);
        send(1'b0, 3'd5, 8'd40, 3'd1);
        send(1'b1, 3'd5, 8'd41, 3'd2);
        send(1'b1, 3'd6, 8'd50, 3'd3);
        idle();
        check("b2b_excl", W'(bus.vpfs_o & a_mask), '0);
        check("b2b_pass", W'(bus.pass_o), W'(3'd6));
        idle();
        check("b2b_pulses", W'(fv_seen), W'(2));

        // Random frames, sometimes back-to-back
        for (int fr = 0; fr < 40; fr++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                logic [7:0] a;
                a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(192, 255))
                                                : 8'($urandom_range(0, 191));
                step(1'b1, i == len - 1, 3'($urandom), a, $urandom_range(0, 7) != 0,
                     3'($urandom));
            end
            repeat ($urandom_range(0, 2)) idle();
        end

        // Encoder loopback: lowest-index winner, mask, repeat
        for (int t = 0; t < 20; t++) begin
            int n;
            int sent;
            orig_vpf = '0;
            orig_cnt = '0;
            n = $urandom_range(0, 8);
            while ($countones(orig_vpf) < n) begin
                int k;
                k = $urandom_range(0, NK - 1);
                orig_vpf[k] = 1'b1;
                orig_cnt[k*NB +: NB] = 3'($urandom);
            end
            work = orig_vpf;
            sent = 0;
            if (n == 0) step(1'b1, 1'b1, 3'(t), 8'd0, 1'b0, 3'd0);
            for (int k = 0; k < NK; k++) begin
                if (work[k]) begin
                    work[k] = 1'b0;
                    sent++;
                    send(sent == n, 3'(t), 8'(k), orig_cnt[k*NB +: NB]);
                end
            end
            idle();
            check("loop_vpf", W'(bus.vpfs_o), W'(orig_vpf));
            check("loop_cnt", bus.cnts_o, orig_cnt);
            check("loop_n", W'(bus.nclusters_o), W'(n));
        end

        // Mid-frame reset: outputs clear asynchronously
        send(1'b0, 3'd7, 8'd60, 3'd1);
        send(1'b0, 3'd7, 8'd61, 3'd1);
        send(1'b0, 3'd7, 8'd62, 3'd1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_vpf", W'(bus.vpfs_o), '0);
        check("rst_cnt", bus.cnts_o, '0);
        check("rst_fv", W'(bus.frame_valid_o), '0);
        check("rst_errs", W'({bus.err_range_o, bus.err_dup_o, bus.err_ovf_o}), '0);
        check("rst_n", W'(bus.nclusters_o), '0);
        model_reset();
        @(negedge clock);
        bus.valid_i = 0;
        reset_n = 1'b1;

        // Full frame after reset; the partial frame must not leak in
        send(1'b0, 3'd2, 8'd100, 3'd5);
        send(1'b1, 3'd2, 8'd0, 3'd0);
        idle();
        check("post_rst_vpf", W'(bus.vpfs_o), W'((192'd1 << 100) | 192'd1));

        // Empty frame: only last with vpf=0
        step(1'b1, 1'b1, 3'd1, 8'd9, 1'b0, 3'd3);
        idle();
        check("empty_vpf", W'(bus.vpfs_o), '0);
        check("empty_n", W'(bus.nclusters_o), '0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
